// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser: FSM states,
// error codes reported on OUT_ERROR_CODE and the default frame start marker.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } state_e;

  localparam logic [1:0] ERR_CHECKSUM = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
  localparam logic [1:0] ERR_LINE     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_PACK = 8'hA5;

endpackage

// File: rtl/uart_frame_timeout_counter.sv
// Inter-pack silence counter: counts while enabled, restarts on clear,
// and pulses expired in the cycle the count reaches TIMEOUT_CYCLES-1.
module uart_frame_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 104166
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    expired = enable && !clear && (count_q == LAST);
    count_d = count_q;
    if (clear || !enable || expired) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Reassembles SYNC/LEN/payload/CHK frames from UART RX pack strobes and presents
// checked payloads on a valid/ack output bank; bad frames are dropped and reported.
module uart_rx_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int NUM_OF_DATA_BITS_IN_PACK = 8,
  parameter int MAX_PAYLOAD              = 16,
  parameter logic [NUM_OF_DATA_BITS_IN_PACK-1:0] SYNC_PACK = DEFAULT_SYNC_PACK,
  parameter int TIMEOUT_CYCLES           = 104166,
  parameter int LEN_W                    = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                                         IN_CLOCK,
  input  logic                                         IN_RESET_N,
  input  logic [NUM_OF_DATA_BITS_IN_PACK-1:0]          IN_RX_DATA,
  input  logic                                         IN_RX_DATA_VALID,
  input  logic                                         IN_RX_ERROR,
  input  logic                                         IN_FRAME_ACK,
  output logic [NUM_OF_DATA_BITS_IN_PACK*MAX_PAYLOAD-1:0] OUT_FRAME_PAYLOAD,
  output logic [LEN_W-1:0]                             OUT_FRAME_LEN,
  output logic                                         OUT_FRAME_VALID,
  output logic                                         OUT_FRAME_ERROR,
  output logic [1:0]                                   OUT_ERROR_CODE,
  output logic                                         OUT_OVERRUN,
  output logic                                         OUT_BUSY
);

  localparam int W   = NUM_OF_DATA_BITS_IN_PACK;
  localparam int BUF = W * MAX_PAYLOAD;

  state_e           state_q, state_d;
  logic [BUF-1:0]   buf_q, buf_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic [BUF-1:0]   pay_q, pay_d;
  logic [LEN_W-1:0] olen_q, olen_d;
  logic             vld_q, vld_d;
  logic             ferr_q, ferr_d;
  logic [1:0]       code_q, code_d;
  logic             ovr_q, ovr_d;

  logic             timeout_expired;
  logic             err_hit;
  logic [1:0]       err_code;
  logic             commit;

  uart_frame_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (IN_CLOCK),
    .rst_n  (IN_RESET_N),
    .clear  (IN_RX_DATA_VALID),
    .enable (state_q != ST_HUNT),
    .expired(timeout_expired)
  );

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    len_d    = len_q;
    pay_d    = pay_q;
    olen_d   = olen_q;
    vld_d    = vld_q;
    code_d   = code_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    err_hit  = 1'b0;
    err_code = ERR_CHECKSUM;
    commit   = 1'b0;

    if (vld_q && IN_FRAME_ACK) begin
      vld_d = 1'b0;
    end

    unique case (state_q)
      ST_HUNT: begin
        if (IN_RX_DATA_VALID && (IN_RX_DATA == SYNC_PACK)) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (IN_RX_DATA_VALID) begin
          if (IN_RX_ERROR) begin
            err_hit  = 1'b1;
            err_code = ERR_LINE;
          end else if ((IN_RX_DATA == '0) || (int'(IN_RX_DATA) > MAX_PAYLOAD)) begin
            err_hit  = 1'b1;
            err_code = ERR_BAD_LEN;
          end else begin
            buf_d   = '0;
            sum_d   = IN_RX_DATA;
            idx_d   = '0;
            len_d   = IN_RX_DATA[LEN_W-1:0];
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (IN_RX_DATA_VALID) begin
          if (IN_RX_ERROR) begin
            err_hit  = 1'b1;
            err_code = ERR_LINE;
          end else begin
            buf_d[idx_q*W +: W] = IN_RX_DATA;
            sum_d = sum_q + IN_RX_DATA;
            idx_d = idx_q + LEN_W'(1);
            if (idx_q == len_q - LEN_W'(1)) begin
              state_d = ST_CHECK;
            end
          end
        end
      end
      ST_CHECK: begin
        if (IN_RX_DATA_VALID) begin
          state_d = ST_HUNT;
          if (IN_RX_ERROR) begin
            err_hit  = 1'b1;
            err_code = ERR_LINE;
          end else if (IN_RX_DATA != sum_q) begin
            err_hit  = 1'b1;
            err_code = ERR_CHECKSUM;
          end else begin
            commit = 1'b1;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // A strobe always clears the counter, so expiry never coincides with a pack.
    if (timeout_expired) begin
      err_hit  = 1'b1;
      err_code = ERR_TIMEOUT;
    end

    if (err_hit) begin
      state_d = ST_HUNT;
      ferr_d  = 1'b1;
      code_d  = err_code;
    end

    if (commit) begin
      if (!vld_q || IN_FRAME_ACK) begin
        pay_d  = buf_q;
        olen_d = len_q;
        vld_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      state_q <= ST_HUNT;
      idx_q   <= '0;
      len_q   <= '0;
      pay_q   <= '0;
      olen_q  <= '0;
      vld_q   <= 1'b0;
      ferr_q  <= 1'b0;
      code_q  <= 2'd0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pay_q   <= pay_d;
      olen_q  <= olen_d;
      vld_q   <= vld_d;
      ferr_q  <= ferr_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
    end
  end

  // Working buffer and running sum are reseeded in LEN before any use.
  always_ff @(posedge IN_CLOCK) begin
    buf_q <= buf_d;
    sum_q <= sum_d;
  end

  assign OUT_FRAME_PAYLOAD = pay_q;
  assign OUT_FRAME_LEN     = olen_q;
  assign OUT_FRAME_VALID   = vld_q;
  assign OUT_FRAME_ERROR   = ferr_q;
  assign OUT_ERROR_CODE    = code_q;
  assign OUT_OVERRUN       = ovr_q;
  assign OUT_BUSY          = (state_q != ST_HUNT);

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed bench for uart_rx_frame_parser with MAX_PAYLOAD=4, TIMEOUT_CYCLES=100.
module tb_uart_rx_frame_parser;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic        ack;
  logic [31:0] payload;
  logic [2:0]  flen;
  logic        fvalid;
  logic        ferr;
  logic [1:0]  code;
  logic        ovr;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  uart_rx_frame_parser #(
    .NUM_OF_DATA_BITS_IN_PACK(8),
    .MAX_PAYLOAD(4),
    .SYNC_PACK(8'hA5),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .IN_CLOCK         (clk),
    .IN_RESET_N       (rst_n),
    .IN_RX_DATA       (rx_data),
    .IN_RX_DATA_VALID (rx_valid),
    .IN_RX_ERROR      (rx_err),
    .IN_FRAME_ACK     (ack),
    .OUT_FRAME_PAYLOAD(payload),
    .OUT_FRAME_LEN    (flen),
    .OUT_FRAME_VALID  (fvalid),
    .OUT_FRAME_ERROR  (ferr),
    .OUT_ERROR_CODE   (code),
    .OUT_OVERRUN      (ovr),
    .OUT_BUSY         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drives one strobe sampled at the next rising edge; returns #1 after it.
  task automatic send(input logic [7:0] d, input logic e = 1'b0);
    rx_data  = d;
    rx_valid = 1'b1;
    rx_err   = e;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  initial begin
    int  cycles;
    logic found;
    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_err = 1'b0; ack = 1'b0;
    #12;
    check("rst_valid", fvalid, 0);
    check("rst_payload", payload, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Good frame
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    check("good_busy_mid", busy, 1);
    send(8'h69);
    check("good_valid", fvalid, 1);
    check("good_len", flen, 3);
    check("good_payload", payload, 32'h00332211);
    check("good_noerr", ferr, 0);
    check("good_busy_after", busy, 0);
    do_ack();
    check("ack_valid", fvalid, 0);
    check("ack_payload_hold", payload, 32'h00332211);

    // Checksum error then a good frame
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h6A);
    check("chk_err_pulse", ferr, 1);
    check("chk_err_code", code, 0);
    check("chk_valid", fvalid, 0);
    idle(1);
    check("chk_err_oneshot", ferr, 0);
    send(8'hA5); send(8'h02); send(8'h01); send(8'h02); send(8'h05);
    check("after_chk_valid", fvalid, 1);
    check("after_chk_payload", payload, 32'h00000201);
    do_ack();

    // Bad lengths
    send(8'hA5); send(8'h05);
    check("len5_err", ferr, 1);
    check("len5_code", code, 1);
    check("len5_busy", busy, 0);
    send(8'hA5); send(8'h00);
    check("len0_err", ferr, 1);
    check("len0_code", code, 1);
    // Leading garbage, then a one-pack frame
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h01); send(8'h44); send(8'h45);
    check("garbage_valid", fvalid, 1);
    check("garbage_len", flen, 1);
    check("garbage_payload", payload, 32'h00000044);
    check("garbage_noerr", ferr, 0);
    do_ack();

    // Timeout: expiry registered on the 100th edge after the last strobe
    send(8'hA5); send(8'h02); send(8'h10);
    found = 1'b0;
    cycles = 0;
    for (int i = 1; i <= 150 && !found; i++) begin
      @(posedge clk);
      #1;
      if (ferr) begin
        found = 1'b1;
        cycles = i;
      end
    end
    check("to_seen", found, 1);
    check("to_cycles", cycles, 100);
    check("to_code", code, 3);
    check("to_busy", busy, 0);

    // Line error mid-payload
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22, 1'b1);
    check("line_err", ferr, 1);
    check("line_code", code, 2);
    check("line_busy", busy, 0);

    // Overrun: second good frame with no ack
    send(8'hA5); send(8'h01); send(8'h11); send(8'h12);
    check("ovr_first_valid", fvalid, 1);
    send(8'hA5); send(8'h01); send(8'h22); send(8'h23);
    check("ovr_pulse", ovr, 1);
    check("ovr_payload_kept", payload, 32'h00000011);
    check("ovr_valid", fvalid, 1);
    idle(1);
    check("ovr_oneshot", ovr, 0);

    // Ack coincident with the commit replaces the frame
    send(8'hA5); send(8'h01); send(8'h33);
    ack = 1'b1;
    send(8'h34);
    ack = 1'b0;
    check("ackc_valid", fvalid, 1);
    check("ackc_payload", payload, 32'h00000033);
    check("ackc_no_ovr", ovr, 0);

    // Async reset mid-frame with a frame still presented
    send(8'hA5); send(8'h03); send(8'h11);
    check("prerst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", fvalid, 0);
    check("arst_payload", payload, 0);
    check("arst_len", flen, 0);
    check("arst_code", code, 0);
    check("arst_busy", busy, 0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    check("postrst_valid", fvalid, 1);
    check("postrst_len", flen, 1);
    check("postrst_payload", payload, 32'h0000007E);
    check("postrst_noerr", ferr, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
